// File: rtl/csb_cmd_packer_pkg.sv
// Shared command-format definitions for the packer and the sequencer.
// Defines the burst length, the op_type encodings and the field bit positions of each word.
package csb_cmd_packer_pkg;

  localparam int CMD_BURST_LEN = 8;

  typedef enum logic [2:0] {
    OP_IDLE    = 3'b000,
    OP_CONV    = 3'b001,
    OP_MAXPOOL = 3'b100,
    OP_AVGPOOL = 3'b101
  } op_e;

  // Word 8: op / stride / kernel / sides
  localparam int W8_OP_LSB     = 0;
  localparam int W8_STRIDE_LSB = 4;
  localparam int W8_KERNEL_LSB = 8;
  localparam int W8_ISIDE_LSB  = 16;
  localparam int W8_OSIDE_LSB  = 24;
  // Word 7: channels
  localparam int W7_ICH_LSB    = 0;
  localparam int W7_OCH_LSB    = 16;
  // Word 6: mask / kernel size / stride2
  localparam int W6_MASK_LSB   = 0;
  localparam int W6_KSIZE_LSB  = 8;
  localparam int W6_STR2_LSB   = 16;
  // Word 1: paddings
  localparam int W1_P0H_LSB    = 0;
  localparam int W1_P0B_LSB    = 8;
  localparam int W1_P1H_LSB    = 16;
  localparam int W1_P1B_LSB    = 24;

  typedef struct packed {
    logic [2:0]  op_type;
    logic [3:0]  stride;
    logic [7:0]  kernel;
    logic [7:0]  i_side;
    logic [7:0]  o_side;
    logic [15:0] i_channel;
    logic [15:0] o_channel;
    logic [1:0]  result_mask;
    logic [7:0]  kernel_size;
    logic [15:0] stride2;
    logic [29:0] weight_start_addr;
    logic [29:0] data_start_addr;
    logic [29:0] p0_result_start_addr;
    logic [29:0] p1_result_start_addr;
    logic [7:0]  p0_padding_head;
    logic [7:0]  p0_padding_body;
    logic [7:0]  p1_padding_head;
    logic [7:0]  p1_padding_body;
  } cmd_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_SEALED
  } state_e;

  // A descriptor the sequencer can execute: nonzero kernel/stride, stride within kernel, real op.
  function automatic logic desc_ok(input cmd_desc_t d);
    logic op_valid;
    op_valid = (d.op_type == OP_CONV) || (d.op_type == OP_MAXPOOL) || (d.op_type == OP_AVGPOOL);
    return op_valid && (d.kernel != 8'd0) && (d.stride != 4'd0) && ({4'd0, d.stride} <= d.kernel);
  endfunction

endpackage

// File: rtl/csb_cmd_word_mux.sv
// Selects one 32-bit command word from the latched descriptor by burst counter value.
// Counter values outside 1..8 yield zero, so dout reads 0 while idle.
module csb_cmd_word_mux
  import csb_cmd_packer_pkg::*;
(
  input  logic [3:0]  sel,
  input  cmd_desc_t   desc,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    case (sel)
      4'd8: begin
        word[W8_OP_LSB     +: 3] = desc.op_type;
        word[W8_STRIDE_LSB +: 4] = desc.stride;
        word[W8_KERNEL_LSB +: 8] = desc.kernel;
        word[W8_ISIDE_LSB  +: 8] = desc.i_side;
        word[W8_OSIDE_LSB  +: 8] = desc.o_side;
      end
      4'd7: begin
        word[W7_ICH_LSB +: 16] = desc.i_channel;
        word[W7_OCH_LSB +: 16] = desc.o_channel;
      end
      4'd6: begin
        word[W6_MASK_LSB  +: 2]  = desc.result_mask;
        word[W6_KSIZE_LSB +: 8]  = desc.kernel_size;
        word[W6_STR2_LSB  +: 16] = desc.stride2;
      end
      4'd5: word = {2'b00, desc.weight_start_addr};
      4'd4: word = {2'b00, desc.data_start_addr};
      4'd3: word = {2'b00, desc.p0_result_start_addr};
      4'd2: word = {2'b00, desc.p1_result_start_addr};
      4'd1: begin
        word[W1_P0H_LSB +: 8] = desc.p0_padding_head;
        word[W1_P0B_LSB +: 8] = desc.p0_padding_body;
        word[W1_P1H_LSB +: 8] = desc.p1_padding_head;
        word[W1_P1B_LSB +: 8] = desc.p1_padding_body;
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/csb_cmd_packer.sv
// Serialises layer descriptors into 8-word commands for the command FIFO and counts them.
// Optional descriptor checking is enabled with the CMD_CHECK_EN macro.
module csb_cmd_packer
  import csb_cmd_packer_pkg::*;
#(
  parameter int BURST_LEN = CMD_BURST_LEN,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op_type,
  input  logic [3:0]       stride,
  input  logic [7:0]       kernel,
  input  logic [7:0]       i_side,
  input  logic [7:0]       o_side,
  input  logic [15:0]      i_channel,
  input  logic [15:0]      o_channel,
  input  logic [1:0]       result_mask,
  input  logic [7:0]       kernel_size,
  input  logic [15:0]      stride2,
  input  logic [29:0]      weight_start_addr,
  input  logic [29:0]      data_start_addr,
  input  logic [29:0]      p0_result_start_addr,
  input  logic [29:0]      p1_result_start_addr,
  input  logic [7:0]       p0_padding_head,
  input  logic [7:0]       p0_padding_body,
  input  logic [7:0]       p1_padding_head,
  input  logic [7:0]       p1_padding_body,
  input  logic             seal,
  input  logic             fifo_full,
  output logic             wr_en,
  output logic [31:0]      dout,
  output logic [CNT_W-1:0] cmd_size,
  output logic             done,
  output logic             err
);

  state_e     state, state_d;
  logic [3:0] cnt, cnt_d;
  cmd_desc_t  desc_in, desc_q;
  logic       load, bump, reject, accept_ok;

  assign desc_in = '{op_type, stride, kernel, i_side, o_side, i_channel, o_channel,
                     result_mask, kernel_size, stride2, weight_start_addr, data_start_addr,
                     p0_result_start_addr, p1_result_start_addr, p0_padding_head,
                     p0_padding_body, p1_padding_head, p1_padding_body};

`ifdef CMD_CHECK_EN
  assign accept_ok = desc_ok(desc_in);
`else
  assign accept_ok = 1'b1;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    load    = 1'b0;
    bump    = 1'b0;
    reject  = 1'b0;
    wr_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        // A descriptor takes priority over seal; seal is picked up once the burst is out.
        if (in_valid) begin
          if (accept_ok) begin
            load    = 1'b1;
            cnt_d   = 4'(BURST_LEN);
            state_d = ST_EMIT;
          end else begin
            reject = 1'b1;
          end
        end else if (seal) begin
          state_d = ST_SEALED;
        end
      end
      ST_EMIT: begin
        wr_en = !fifo_full;
        if (wr_en) begin
          cnt_d = cnt - 4'd1;
          if (cnt == 4'd1) begin
            bump    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      desc_q   <= '0;
      cmd_size <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (load) desc_q <= desc_in;
      if (bump && (cmd_size != {CNT_W{1'b1}})) cmd_size <= cmd_size + 1'b1;
    end
  end

`ifdef CMD_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= reject;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // in_ready is masked by rst so every output reads 0 while reset is held.
  assign in_ready = (state == ST_IDLE) && !rst;
  assign done     = (state == ST_SEALED);

  csb_cmd_word_mux u_word_mux (
    .sel  (cnt),
    .desc (desc_q),
    .word (dout)
  );

endmodule

// File: tb/tb_csb_cmd_packer.sv
// Randomised and directed bench for csb_cmd_packer against a field-concatenation reference model.
module tb_csb_cmd_packer;
  import csb_cmd_packer_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, seal, fifo_full;
  logic        in_ready, wr_en, done, err;
  logic [31:0] dout;
  logic [6:0]  cmd_size;
  cmd_desc_t   d_in;

  int          vec = 0;
  int          miss = 0;
  int          exp_size = 0;
  logic [31:0] exp_w [8];
  logic [31:0] obs_w [8];

  always #5 clk = ~clk;

  csb_cmd_packer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_type(d_in.op_type), .stride(d_in.stride), .kernel(d_in.kernel),
    .i_side(d_in.i_side), .o_side(d_in.o_side), .i_channel(d_in.i_channel),
    .o_channel(d_in.o_channel), .result_mask(d_in.result_mask),
    .kernel_size(d_in.kernel_size), .stride2(d_in.stride2),
    .weight_start_addr(d_in.weight_start_addr), .data_start_addr(d_in.data_start_addr),
    .p0_result_start_addr(d_in.p0_result_start_addr),
    .p1_result_start_addr(d_in.p1_result_start_addr),
    .p0_padding_head(d_in.p0_padding_head), .p0_padding_body(d_in.p0_padding_body),
    .p1_padding_head(d_in.p1_padding_head), .p1_padding_body(d_in.p1_padding_body),
    .seal(seal), .fifo_full(fifo_full), .wr_en(wr_en), .dout(dout),
    .cmd_size(cmd_size), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec++;
    assert (obs === expv) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: the eight words, in emission order, straight from the field layout.
  task automatic build(input cmd_desc_t d);
    exp_w[0] = {d.o_side, d.i_side, d.kernel, d.stride, 1'b0, d.op_type};
    exp_w[1] = {d.o_channel, d.i_channel};
    exp_w[2] = {d.stride2, d.kernel_size, 6'b0, d.result_mask};
    exp_w[3] = {2'b00, d.weight_start_addr};
    exp_w[4] = {2'b00, d.data_start_addr};
    exp_w[5] = {2'b00, d.p0_result_start_addr};
    exp_w[6] = {2'b00, d.p1_result_start_addr};
    exp_w[7] = {d.p1_padding_body, d.p1_padding_head, d.p0_padding_body, d.p0_padding_head};
  endtask

  task automatic rand_desc(output cmd_desc_t d);
    logic [2:0] ops [3];
    int k;
    ops = '{3'b001, 3'b100, 3'b101};
    d = cmd_desc_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom});
    d.op_type = ops[$urandom_range(0, 2)];
    k = $urandom_range(1, 255);
    d.kernel = 8'(k);
    d.stride = 4'($urandom_range(1, (k < 15) ? k : 15));
  endtask

  // Handshake one descriptor, then follow the burst cycle by cycle with the given stall mask.
  task automatic send_cmd(input cmd_desc_t d, input logic [31:0] stall, input logic hold_seal);
    cmd_desc_t junk;
    int writes, cyc, last, exp_last, zeros;
    zeros = 0; exp_last = 0;
    for (int c = 1; c < 32 && zeros < 8; c++) if (!stall[c]) begin zeros++; exp_last = c; end
    @(negedge clk);
    d_in = d; in_valid = 1'b1; seal = hold_seal; fifo_full = 1'b0;
    #1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    chk("wr_en_idle", 32'(wr_en), 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rand_desc(junk);
    d_in = junk;
    build(d);
    writes = 0; cyc = 1; last = 0;
    while (writes < 8 && cyc < 32) begin
      fifo_full = stall[cyc];
      #1;
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      chk("wr_en", 32'(wr_en), 32'(!fifo_full));
      chk("dout", dout, exp_w[writes]);
      if (wr_en) begin
        obs_w[writes] = dout;
        writes++;
        last = cyc;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    fifo_full = 1'b0;
    #1;
    chk("burst_words", 32'(writes), 32'd8);
    chk("last_write_cycle", 32'(last), 32'(exp_last));
    if (exp_size < 127) exp_size++;
    chk("in_ready_after", 32'(in_ready), 32'd1);
    chk("cmd_size", 32'(cmd_size), 32'(exp_size));
    chk("err_quiet", 32'(err), 32'd0);
  endtask

  initial begin
    cmd_desc_t d;
    rst = 1'b1; in_valid = 1'b0; seal = 1'b0; fifo_full = 1'b0; d_in = '0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_cmd_size", 32'(cmd_size), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed conv command, no backpressure.
    d = '0;
    d.op_type = 3'b001; d.stride = 4'd1; d.kernel = 8'd3; d.i_side = 8'd227; d.o_side = 8'd113;
    d.i_channel = 16'd3; d.o_channel = 16'd64; d.weight_start_addr = 30'h1000;
    send_cmd(d, 32'h0, 1'b0);
    chk("conv_word8", obs_w[0], 32'h71E30311);
    chk("conv_word7", obs_w[1], 32'h00400003);
    chk("conv_word5", obs_w[3], 32'h00001000);

    // Stall on burst cycles 3..5: dout parks on word 6, last write on cycle 11.
    rand_desc(d);
    send_cmd(d, 32'h38, 1'b0);

    // Back-to-back.
    for (int i = 0; i < 3; i++) begin
      rand_desc(d);
      send_cmd(d, 32'h0, 1'b0);
    end

`ifdef CMD_CHECK_EN
    d = '0; d.op_type = 3'b001; d.stride = 4'd4; d.kernel = 8'd3;
    @(negedge clk);
    d_in = d; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("reject_err", 32'(err), 32'd1);
    chk("reject_wr_en", 32'(wr_en), 32'd0);
    chk("reject_in_ready", 32'(in_ready), 32'd1);
    chk("reject_cmd_size", 32'(cmd_size), 32'(exp_size));
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("reject_err_pulse", 32'(err), 32'd0);
    d.stride = 4'd2;
    send_cmd(d, 32'h0, 1'b0);
`endif

    // Random stalls (including on the last word) run the counter into saturation.
    while (exp_size < 127) begin
      rand_desc(d);
      send_cmd(d, ($urandom & $urandom) & 32'h0001FFFE, 1'b0);
    end
    rand_desc(d);
    send_cmd(d, 32'h0, 1'b0);
    chk("cmd_size_sat", 32'(cmd_size), 32'd127);

    // Reset after the fourth word.
    rand_desc(d);
    @(negedge clk);
    d_in = d; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    #1;
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_cmd_size", 32'(cmd_size), 32'd0);
    chk("midrst_dout", dout, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_size = 0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);

    // Seal after two commands; seal arrives together with the second descriptor.
    rand_desc(d);
    send_cmd(d, 32'h0, 1'b0);
    rand_desc(d);
    send_cmd(d, 32'h0, 1'b1);
    chk("seal_not_yet", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("sealed_done", 32'(done), 32'd1);
    chk("sealed_in_ready", 32'(in_ready), 32'd0);
    chk("sealed_cmd_size", 32'(cmd_size), 32'd2);
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("sealed_no_write", 32'(wr_en), 32'd0);
      chk("sealed_hold", 32'(done), 32'd1);
    end
    in_valid = 1'b0;
    seal = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
